// File: rtl/stock_pkg.sv
// -----------------------------------------------------------------------------
// stock_pkg
// Shared types and sizing for the vending-machine stock ledger.
//   SLOTS / CNT_W / PRICE_W : slot count and entry field widths
//   op_e                    : request opcodes
//   status_e                : response status codes
//   stock_entry_t           : one slot entry, {count, price}
//   state_e                 : ledger FSM states
// -----------------------------------------------------------------------------
package stock_pkg;

  localparam int SLOTS   = 8;
  localparam int SLOT_W  = 3;
  localparam int CNT_W   = 4;
  localparam int PRICE_W = 7;
  localparam int CNT_MAX = 15;
  localparam int ENTRY_W = CNT_W + PRICE_W;

  typedef enum logic [1:0] {
    OP_VEND     = 2'b00,
    OP_RESTOCK  = 2'b01,
    OP_SETPRICE = 2'b10,
    OP_RSVD     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK    = 2'b00,
    ST_EMPTY = 2'b01,
    ST_FULL  = 2'b10,
    ST_BADOP = 2'b11
  } status_e;

  typedef struct packed {
    logic [CNT_W-1:0]   count;
    logic [PRICE_W-1:0] price;
  } stock_entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/stock_ledger_if.sv
// -----------------------------------------------------------------------------
// stock_ledger_if
// Request/response handshake between a requester and the stock ledger.
//   req_valid/req_ready : request handshake
//   req_op/slot/arg     : request payload
//   resp_valid          : one-cycle response strobe with resp_status/resp_price
// Modports: master = requester, slave = ledger.
// -----------------------------------------------------------------------------
interface stock_ledger_if;
  import stock_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_op;
  logic [SLOT_W-1:0]  req_slot;
  logic [PRICE_W-1:0] req_arg;
  logic               resp_valid;
  logic [1:0]         resp_status;
  logic [PRICE_W-1:0] resp_price;

  modport master (
    output req_valid, req_op, req_slot, req_arg,
    input  req_ready, resp_valid, resp_status, resp_price
  );

  modport slave (
    input  req_valid, req_op, req_slot, req_arg,
    output req_ready, resp_valid, resp_status, resp_price
  );

endinterface

// File: rtl/stock_alu.sv
// -----------------------------------------------------------------------------
// stock_alu
// Combinational evaluation of one ledger request against one slot entry.
//   op        in  : latched opcode
//   entry     in  : current slot entry
//   arg       in  : restock quantity (low CNT_W bits) or new price
//   new_entry out : entry to write back (equals entry when nothing changes)
//   status    out : response status
//   changed   out : new_entry differs from entry
//   price     out : slot price for a successful vend, else 0
// -----------------------------------------------------------------------------
module stock_alu
  import stock_pkg::*;
(
  input  op_e                op,
  input  stock_entry_t       entry,
  input  logic [PRICE_W-1:0] arg,
  output stock_entry_t       new_entry,
  output status_e            status,
  output logic               changed,
  output logic [PRICE_W-1:0] price
);

  // One bit wider than a count so an overflowing restock is detectable.
  logic [CNT_W:0] sum;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    new_entry = entry;
    status    = ST_OK;
    changed   = 1'b0;
    price     = '0;
    sum       = {1'b0, entry.count} + {1'b0, arg[CNT_W-1:0]};

    case (op)
      OP_VEND: begin
        if (entry.count == '0) begin
          status = ST_EMPTY;
        end else begin
          new_entry.count = entry.count - 1'b1;
          changed         = 1'b1;
          price           = entry.price;
        end
      end
      OP_RESTOCK: begin
        // An overflowing restock is refused outright rather than saturated.
        if (sum > (CNT_W+1)'(CNT_MAX)) begin
          status = ST_FULL;
        end else if (arg[CNT_W-1:0] != '0) begin
          new_entry.count = sum[CNT_W-1:0];
          changed         = 1'b1;
        end
      end
      OP_SETPRICE: begin
        new_entry.price = arg;
        changed         = (arg != entry.price);
      end
      default: begin
        status = ST_BADOP;
      end
    endcase
  end

endmodule

// File: rtl/stock_ledger.sv
// -----------------------------------------------------------------------------
// stock_ledger
// Live per-slot inventory of the vending machine. Serialises vend, restock and
// price-change requests (IDLE -> EXEC -> RESP) and publishes the entry image.
//   clock        in  : rising-edge clock
//   reset        in  : synchronous, active-high
//   bus          slv : request/response handshake (stock_ledger_if.slave)
//   data         out : registered entry image, data[i] = {count, price}
//   data_update  out : one-cycle pulse in RESP when the entry changed
//   low_stock    out : per-slot (count <= 1), registered; present only when
//                      STOCK_LOW_ALERT_EN is defined
// -----------------------------------------------------------------------------
module stock_ledger
  import stock_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  stock_ledger_if.slave  bus,
  output stock_entry_t   data [0:SLOTS-1],
  output logic           data_update
`ifdef STOCK_LOW_ALERT_EN
  ,
  output logic [SLOTS-1:0] low_stock
`endif
);

  state_e             state_q, state_d;
  op_e                op_q;
  logic [SLOT_W-1:0]  slot_q;
  logic [PRICE_W-1:0] arg_q;
  status_e            status_q;
  logic [PRICE_W-1:0] price_q;
  logic               changed_q;

  stock_entry_t       alu_entry;
  status_e            alu_status;
  logic               alu_changed;
  logic [PRICE_W-1:0] alu_price;

  stock_alu u_alu (
    .op        (op_q),
    .entry     (data[slot_q]),
    .arg       (arg_q),
    .new_entry (alu_entry),
    .status    (alu_status),
    .changed   (alu_changed),
    .price     (alu_price)
  );

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. Reset forces IDLE through the register, so a request
  // seen here while reset is high never takes effect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.req_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, entry array and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the entry array is deliberately reset: the persistence stage
      // downstream must see a defined all-zero image after reset.
      for (int i = 0; i < SLOTS; i++) data[i] <= '0;
      op_q      <= OP_VEND;
      slot_q    <= '0;
      arg_q     <= '0;
      status_q  <= ST_OK;
      price_q   <= '0;
      changed_q <= 1'b0;
`ifdef STOCK_LOW_ALERT_EN
      low_stock <= '1;
`endif
    end else begin
      if (state_q == S_IDLE && bus.req_valid) begin
        op_q   <= op_e'(bus.req_op);
        slot_q <= bus.req_slot;
        arg_q  <= bus.req_arg;
      end
      if (state_q == S_EXEC) begin
        data[slot_q] <= alu_entry;
        status_q     <= alu_status;
        price_q      <= alu_price;
        changed_q    <= alu_changed;
`ifdef STOCK_LOW_ALERT_EN
        low_stock[slot_q] <= (alu_entry.count <= CNT_W'(1));
`endif
      end
    end
  end

  // Outputs. Gating with reset keeps every strobe low while reset is held,
  // even in the cycle before the state register has been cleared.
  always_comb begin
    bus.req_ready   = (state_q == S_IDLE) && !reset;
    bus.resp_valid  = (state_q == S_RESP) && !reset;
    bus.resp_status = bus.resp_valid ? status_q : ST_OK;
    bus.resp_price  = bus.resp_valid ? price_q  : '0;
    data_update     = bus.resp_valid && changed_q;
  end

endmodule
